// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op encodings, flag positions and operand-conditioning helpers
package alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ADC = 2'b10,
        OP_SBC = 2'b11
    } alu_op_e;

    // Bit positions inside the packed {n,z,c,v} vector used by the condition-code register
    localparam int FLAG_N  = 3;
    localparam int FLAG_Z  = 2;
    localparam int FLAG_C  = 1;
    localparam int FLAG_V  = 0;
    localparam int FLAGS_W = 4;

    function automatic logic op_inverts_b(input logic [1:0] op);
        return (op == OP_SUB) || (op == OP_SBC);
    endfunction

    function automatic logic op_carry_in(input logic [1:0] op, input logic cin);
        logic c0;
        case (op)
            OP_ADD:  c0 = 1'b0;
            OP_SUB:  c0 = 1'b1;
            default: c0 = cin;
        endcase
        return c0;
    endfunction

endpackage

// File: rtl/cla_segment.sv
// rtl/cla_segment.sv - combinational SEG-bit adder from 4-bit carry-lookahead groups
module cla_segment #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout
);

    localparam int GROUPS = SEG / 4;

    logic [SEG-1:0] w_g;
    logic [SEG-1:0] w_p;
    logic [SEG:0]   w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // Every carry inside a group depends only on the group carry-in; groups chain on their G/P
    always_comb begin
        w_c    = '0;
        w_c[0] = cin;
        for (int j = 0; j < GROUPS; j++) begin
            w_c[4*j+1] = w_g[4*j] | (w_p[4*j] & w_c[4*j]);
            w_c[4*j+2] = w_g[4*j+1] | (w_p[4*j+1] & w_g[4*j])
                       | ((&w_p[4*j +: 2]) & w_c[4*j]);
            w_c[4*j+3] = w_g[4*j+2] | (w_p[4*j+2] & w_g[4*j+1])
                       | ((&w_p[4*j+1 +: 2]) & w_g[4*j])
                       | ((&w_p[4*j +: 3]) & w_c[4*j]);
            w_c[4*j+4] = w_g[4*j+3] | (w_p[4*j+3] & w_g[4*j+2])
                       | ((&w_p[4*j+2 +: 2]) & w_g[4*j+1])
                       | ((&w_p[4*j+1 +: 3]) & w_g[4*j])
                       | ((&w_p[4*j +: 4]) & w_c[4*j]);
        end
    end

    assign sum  = w_p ^ w_c[SEG-1:0];
    assign cout = w_c[SEG];

endmodule

// File: rtl/pipelined_addsub.sv
// rtl/pipelined_addsub.sv - pipelined add/sub unit, one CLA segment per stage with valid/ready flow
module pipelined_addsub
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SEG   = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic             in_cin,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_n,
    output logic             out_z,
    output logic             out_c,
    output logic             out_v
);

    localparam int STAGES = WIDTH / SEG;

    logic               w_ready [STAGES+1];
    logic               r_valid [STAGES];
    logic [WIDTH-1:0]   r_a     [STAGES];
    logic [WIDTH-1:0]   r_b     [STAGES];
    logic [WIDTH-1:0]   r_sum   [STAGES];
    logic               r_carry [STAGES];
    logic [TAG_W-1:0]   r_tag   [STAGES];
    logic [FLAGS_W-1:0] r_flags;

    assign w_ready[STAGES] = out_ready;
    assign in_ready        = w_ready[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic             w_src_valid;
        logic [WIDTH-1:0] w_src_a;
        logic [WIDTH-1:0] w_src_b;
        logic [WIDTH-1:0] w_src_sum;
        logic             w_src_c;
        logic [TAG_W-1:0] w_src_tag;
        logic [SEG-1:0]   w_seg_sum;
        logic             w_seg_cout;
        logic [WIDTH-1:0] w_next_sum;

        assign w_ready[k] = ~r_valid[k] | w_ready[k+1];

        if (k == 0) begin : g_first
            assign w_src_valid = in_valid;
            assign w_src_a     = in_a;
            assign w_src_b     = op_inverts_b(in_op) ? ~in_b : in_b;
            assign w_src_c     = op_carry_in(in_op, in_cin);
            assign w_src_sum   = '0;
            assign w_src_tag   = in_tag;
        end else begin : g_next
            assign w_src_valid = r_valid[k-1];
            assign w_src_a     = r_a[k-1];
            assign w_src_b     = r_b[k-1];
            assign w_src_c     = r_carry[k-1];
            assign w_src_sum   = r_sum[k-1];
            assign w_src_tag   = r_tag[k-1];
        end

        cla_segment #(.SEG(SEG)) u_seg (
            .a    (w_src_a[k*SEG +: SEG]),
            .b    (w_src_b[k*SEG +: SEG]),
            .cin  (w_src_c),
            .sum  (w_seg_sum),
            .cout (w_seg_cout)
        );

        // Lower slices are already final; only slice k is filled in here
        always_comb begin
            w_next_sum                = w_src_sum;
            w_next_sum[k*SEG +: SEG]  = w_seg_sum;
        end

        always_ff @(posedge clk) begin
            if (clr) begin
                r_valid[k] <= 1'b0;
                r_a[k]     <= '0;
                r_b[k]     <= '0;
                r_sum[k]   <= '0;
                r_carry[k] <= 1'b0;
                r_tag[k]   <= '0;
            end else if (w_ready[k]) begin
                r_valid[k] <= w_src_valid;
                if (w_src_valid) begin
                    r_a[k]     <= w_src_a;
                    r_b[k]     <= w_src_b;
                    r_sum[k]   <= w_next_sum;
                    r_carry[k] <= w_seg_cout;
                    r_tag[k]   <= w_src_tag;
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            logic [FLAGS_W-1:0] w_flags;

            always_comb begin
                w_flags         = '0;
                w_flags[FLAG_N] = w_next_sum[WIDTH-1];
                w_flags[FLAG_Z] = (w_next_sum == '0);
                w_flags[FLAG_C] = w_seg_cout;
                w_flags[FLAG_V] = (w_src_a[WIDTH-1] == w_src_b[WIDTH-1])
                                && (w_next_sum[WIDTH-1] != w_src_a[WIDTH-1]);
            end

            always_ff @(posedge clk) begin
                if (clr) begin
                    r_flags <= '0;
                end else if (w_ready[k] && w_src_valid) begin
                    r_flags <= w_flags;
                end
            end
        end
    end

    assign out_valid = r_valid[STAGES-1];
    assign out_sum   = r_sum[STAGES-1];
    assign out_tag   = r_tag[STAGES-1];
    assign out_n     = r_flags[FLAG_N];
    assign out_z     = r_flags[FLAG_Z];
    assign out_c     = r_flags[FLAG_C];
    assign out_v     = r_flags[FLAG_V];

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb/tb_pipelined_addsub.sv - vector table, directed corner sequences and randomized scoreboard run
module tb_pipelined_addsub;
    import alu_pkg::*;

    localparam int WIDTH  = 32;
    localparam int SEG    = 8;
    localparam int TAG_W  = 4;
    localparam int STAGES = WIDTH / SEG;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic             clk;
    logic             clr;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic             in_cin;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic [TAG_W-1:0] out_tag;
    logic             out_n, out_z, out_c, out_v;

    pipelined_addsub #(.WIDTH(WIDTH), .SEG(SEG), .TAG_W(TAG_W)) dut (
        .clk(clk), .clr(clr),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_tag(out_tag),
        .out_n(out_n), .out_z(out_z), .out_c(out_c), .out_v(out_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain modular arithmetic for sum/carry, 64-bit signed range test for overflow
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op, input logic cin);
        logic [31:0] bb;
        logic        c0;
        logic [32:0] full;
        longint      s;
        logic        v;
        bb   = (op == OP_SUB || op == OP_SBC) ? ~b : b;
        c0   = (op == OP_ADD) ? 1'b0 : (op == OP_SUB) ? 1'b1 : cin;
        full = {1'b0, a} + {1'b0, bb} + {32'd0, c0};
        s    = longint'($signed(a)) + longint'($signed(bb)) + longint'(c0);
        v    = (s > SMAX) || (s < SMIN);
        return {full[31:0], full[31], (full[31:0] == 32'd0), full[32], v};
    endfunction

    typedef struct {
        logic [31:0] sum;
        logic [3:0]  flags;
        logic [3:0]  tag;
    } exp_t;

    exp_t        sb_q[$];
    logic        prev_stall = 1'b0;
    logic [40:0] prev_out;

    always @(posedge clk) begin
        logic [35:0] m;
        exp_t        e;
        if (clr) begin
            sb_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {out_valid, out_sum, out_tag, out_n, out_z, out_c, out_v}, prev_out);
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_output actual=tag%0d required=none", out_tag);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_sum", out_sum, e.sum);
                    chk("sb_tag", out_tag, e.tag);
                    chk("sb_flags", {out_n, out_z, out_c, out_v}, e.flags);
                end
            end
            if (in_valid && in_ready) begin
                m = model(in_a, in_b, in_op, in_cin);
                e.sum = m[35:4];
                e.flags = m[3:0];
                e.tag = in_tag;
                sb_q.push_back(e);
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_valid, out_sum, out_tag, out_n, out_z, out_c, out_v};
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic        cin;
        logic [3:0]  tag;
        logic [31:0] sum;
        logic [3:0]  flags;
    } vec_t;

    vec_t vecs[11];

    task automatic run_vec(input vec_t v, input string name);
        int lat;
        in_valid = 1'b1;
        in_a = v.a; in_b = v.b; in_op = v.op; in_cin = v.cin; in_tag = v.tag;
        chk({name, "_in_ready"}, in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 12) begin
            tick();
            lat++;
        end
        chk({name, "_latency"}, lat, STAGES);
        chk({name, "_sum"}, out_sum, v.sum);
        chk({name, "_tag"}, out_tag, v.tag);
        chk({name, "_flags"}, {out_n, out_z, out_c, out_v}, v.flags);
    endtask

    initial begin
        int          bad;
        int          sent;
        int          got_tags[$];
        int          got_cyc[$];
        logic [40:0] snap;
        logic [31:0] pick [5];

        vecs[0]  = '{32'h7FFFFFFF, 32'h00000001, OP_ADD, 1'b0, 4'd3,  32'h80000000, 4'b1001};
        vecs[1]  = '{32'h00000005, 32'h00000005, OP_SUB, 1'b0, 4'd1,  32'h00000000, 4'b0110};
        vecs[2]  = '{32'h00000000, 32'h00000001, OP_SUB, 1'b0, 4'd2,  32'hFFFFFFFF, 4'b1000};
        vecs[3]  = '{32'h80000000, 32'h00000001, OP_SUB, 1'b0, 4'd4,  32'h7FFFFFFF, 4'b0011};
        vecs[4]  = '{32'hFFFFFFFF, 32'h00000000, OP_ADC, 1'b1, 4'd5,  32'h00000000, 4'b0110};
        vecs[5]  = '{32'h0000000A, 32'h00000003, OP_SBC, 1'b0, 4'd6,  32'h00000006, 4'b0010};
        vecs[6]  = '{32'hFFFFFFFF, 32'h00000001, OP_ADD, 1'b0, 4'd7,  32'h00000000, 4'b0110};
        vecs[7]  = '{32'h00000001, 32'h00000002, OP_ADC, 1'b1, 4'd8,  32'h00000004, 4'b0000};
        vecs[8]  = '{32'h00000005, 32'h00000005, OP_SBC, 1'b1, 4'd9,  32'h00000000, 4'b0110};
        vecs[9]  = '{32'h00000001, 32'h00000001, OP_ADD, 1'b1, 4'd10, 32'h00000002, 4'b0000};
        vecs[10] = '{32'h00000007, 32'h00000002, OP_SUB, 1'b0, 4'd11, 32'h00000005, 4'b0010};

        pick[0] = 32'h00000000; pick[1] = 32'hFFFFFFFF; pick[2] = 32'h80000000;
        pick[3] = 32'h7FFFFFFF; pick[4] = 32'h00000001;

        // Reset held two cycles while an operation is offered
        clr = 1'b1; in_valid = 1'b1; in_a = 32'h12345678; in_b = 32'h1; in_op = OP_ADD;
        in_cin = 1'b0; in_tag = 4'd5; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        in_valid = 1'b0;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_sum", out_sum, 32'd0);
        chk("reset_out_tag", out_tag, 4'd0);
        chk("reset_flags", {out_n, out_z, out_c, out_v}, 4'b0000);
        chk("reset_in_ready", in_ready, 1'b1);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) bad++;
        end
        chk("reset_no_output", bad, 0);

        for (int i = 0; i < 11; i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));
        tick();

        // Eight back-to-back ops, consumer stalls in cycles 5..7
        sent = 0;
        for (int c = 0; c < 40 && got_tags.size() < 8; c++) begin
            out_ready = !(c >= 5 && c <= 7);
            if (sent < 8) begin
                in_valid = 1'b1;
                in_a = $urandom; in_b = $urandom; in_op = 2'($urandom); in_cin = 1'($urandom);
                in_tag = 4'(sent);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c == 5) begin
                chk("stream_in_ready_drop", in_ready, 1'b0);
                snap = {out_valid, out_sum, out_tag, out_n, out_z, out_c, out_v};
            end
            if (c == 6 || c == 7) begin
                chk("stream_stall_stable", {out_valid, out_sum, out_tag, out_n, out_z, out_c, out_v}, snap);
                chk("stream_stall_in_ready", in_ready, 1'b0);
            end
            if (out_valid && out_ready) begin
                got_tags.push_back(int'(out_tag));
                got_cyc.push_back(c);
            end
            if (in_valid && in_ready) sent++;
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stream_count", got_tags.size(), 8);
        if (got_tags.size() == 8) begin
            for (int i = 0; i < 8; i++)
                chk($sformatf("stream_tag%0d", i), got_tags[i], i);
            chk("stream_first_out_cycle", got_cyc[0], 4);
            chk("stream_full_rate", got_cyc[7] - got_cyc[1], 6);
        end
        repeat (2) tick();

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_a      = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
            in_b      = ($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 4)] : $urandom;
            in_op     = 2'($urandom);
            in_cin    = 1'($urandom);
            in_tag    = 4'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && (sb_q.size() != 0 || out_valid); i++) tick();
        chk("random_drain_empty", sb_q.size(), 0);
        chk("random_drain_out_valid", out_valid, 1'b0);

        // Three operations in flight discarded by clr
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = 32'(i + 1); in_b = 32'd100; in_op = OP_ADD; in_cin = 1'b0;
            in_tag = 4'(12 + i);
            tick();
        end
        in_valid = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_out_valid", out_valid, 1'b0);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid) bad++;
        end
        chk("clr_no_emit", bad, 0);
        run_vec('{32'd2, 32'd2, OP_ADD, 1'b0, 4'd9, 32'd4, 4'b0000}, "post_clr_add");
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined add/subtract unit for the datapath ALU; the next generation of the 32-bit CLA adder.
- Splits a WIDTH-bit operation into SEG-bit carry-lookahead segments, one pipeline stage per segment, with the carry registered between stages.
- Adds subtract and add/sub-with-carry modes, N/Z/C/V flags, a tag pass-through, and a valid/ready handshake with per-stage back-pressure.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of SEG.
- SEG, 8, bits per stage; must be a multiple of 4 (built from 4-bit lookahead groups).
- TAG_W, 4, width of the sideband tag carried alongside each operation.
- Derived: STAGES = WIDTH/SEG (latency in cycles).

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  synchronous, active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  unit accepts the operation this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_op  in  2  00 ADD, 01 SUB, 10 ADC, 11 SBC.
- in_cin  in  1  carry-in; used by ADC/SBC only.
- in_tag  in  TAG_W  sideband tag, returned unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_sum  out  WIDTH  result.
- out_tag  out  TAG_W  tag of the result.
- out_n, out_z, out_c, out_v  out  1 each  negative, zero, carry-out, signed overflow.

Behaviour:
- Reset: one clock, clk, rising edge; reset clr is synchronous and active-high. While clr is sampled high, all stage valids clear. On the next edge: out_valid=0, out_sum=0, out_tag=0, all flags 0, in_ready=1. Data registers may also be zeroed.
- Operand conditioning at stage 0:
  - ADD: b'=b, c0=0.
  - SUB: b'=~b, c0=1.
  - ADC: b'=b, c0=in_cin.
  - SBC: b'=~b, c0=in_cin (borrow convention: cin=1 means no borrow).
- Transfer: the input transfers when in_valid && in_ready. The output transfers when out_valid && out_ready.
- Stage k (0..STAGES-1) adds slice k of a and b' with the carry registered by stage k-1 (c0 for stage 0). It registers the sum slice and the carry-out.
- Skew handling: unprocessed upper slices of a and b' travel with the operation. Completed lower slices are carried forward, so each operation moves as one record.
- Latency: exactly STAGES cycles from acceptance to out_valid when unstalled. Throughput is one operation per cycle.
- Handshake, per stage: ready_k = ~valid_k | ready_{k+1}; ready_STAGES = out_ready; in_ready = ready_0.
  - Bubbles collapse.
  - A stalled stage holds its contents stable.
  - in_ready is combinational from out_ready through the valid chain.
- Stall rules:
  - out_sum, out_tag and the flags must not change while out_valid=1 and out_ready=0.
  - No operation is lost, duplicated or reordered.
- Flags, computed in the last stage:
  - n = sum[WIDTH-1].
  - z = (sum == 0).
  - c = carry out of bit WIDTH-1. For SUB, c=1 means no borrow.
  - v = (a[msb] == b'[msb]) && (sum[msb] != a[msb]).
- Wrap-around: sums are modulo 2^WIDTH. The carry ripples correctly across all stages, e.g. 0xFFFFFFFF+1.
- Simultaneous accept and emit in one cycle when full and out_ready=1: sustained full throughput, no gap.
- clr mid-operation: in-flight operations are discarded. No result for them is ever emitted.
- Inputs are ignored when in_valid=0. in_tag and in_op are sampled only on acceptance.

Decomposition:
- Shared package (alu_pkg) holds:
  - op encodings: OP_ADD=2'b00, OP_SUB=2'b01, OP_ADC=2'b10, OP_SBC=2'b11;
  - flag bit positions for a packed {n,z,c,v} vector, used by the condition-code register.
- One sub-module, cla_segment: combinational SEG-bit carry-lookahead adder (a, b, cin, sum, cout), built from 4-bit lookahead groups. It is instantiated once per stage via generate.

Test Plan (WIDTH=32, SEG=8, STAGES=4):
- Reset: hold clr 2 cycles with in_valid=1 -> out_valid=0, flags 0, in_ready=1 after release; no spurious output.
- ADD 0x7FFFFFFF+0x00000001, tag 3 -> exactly 4 cycles later: sum 0x80000000, n=1, z=0, c=0, v=1, tag 3.
- SUB 5-5 -> sum 0, z=1, c=1, v=0. SUB 0-1 -> 0xFFFFFFFF, n=1, c=0, v=0. SUB 0x80000000-1 -> 0x7FFFFFFF, v=1.
- ADC 0xFFFFFFFF+0+cin=1 -> sum 0, c=1, z=1 (carry crosses all 4 stages). SBC 10-3 with cin=0 -> 6, c=1.
- Stream 8 ops back-to-back with tags 0..7 and out_ready=0 for cycles 5-7:
  - in_ready drops once 4 are held;
  - outputs stay stable while stalled;
  - all 8 emerge in tag order, none lost or duplicated;
  - full rate resumes on release.
- Assert clr with 3 operations in flight -> out_valid=0 next cycle and none of them are ever emitted; a new ADD 2+2 afterwards -> 4, after 4 cycles.
